// File: rtl/gshare_pkg.sv
// Shared types and constants for the gshare pattern history table.
// The index width also sets the global history register width.
package gshare_pkg;

  localparam int IDX_W  = 10;
  localparam int PC_LSB = 2;

  typedef logic [1:0] pht_cnt_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_e;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic pht_cnt_t sat_update(pht_cnt_t cnt, logic taken);
    pht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Gshare PHT: combinational prediction from PC^GHR, trained at resolve, plus perf counters.
// Optional GSHARE_BYPASS_EN forwards a same-index update into the same-cycle prediction.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int       IDX_W    = gshare_pkg::IDX_W,
  parameter int       PC_LSB   = gshare_pkg::PC_LSB,
  parameter pht_cnt_t CNT_INIT = 2'b01,
  parameter int       PERF_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_pred_pc,
  input  logic [IDX_W-1:0]  i_ghr,
  output logic              o_pred_taken,
  output logic [IDX_W-1:0]  o_pred_idx,
  input  logic              i_upd_valid,
  input  logic [IDX_W-1:0]  i_upd_idx,
  input  logic              i_upd_taken,
  input  logic              i_upd_pred_taken,
  output logic              o_ghr_enable,
  output logic              o_ghr_bit,
  output logic              o_mispredict,
  output logic [PERF_W-1:0] o_br_count,
  output logic [PERF_W-1:0] o_mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;

  pht_cnt_t          pht [ENTRIES];
  logic [IDX_W-1:0]  pred_idx;
  pht_cnt_t          pred_cnt;
  logic              mispredict;
  logic [PERF_W-1:0] br_count;
  logic [PERF_W-1:0] mispred_count;
  logic              unused_pc;

  // PC bits outside the index window do not participate in the hash.
  assign unused_pc = ^{i_pred_pc[31:PC_LSB+IDX_W], i_pred_pc[PC_LSB-1:0]};

  assign pred_idx   = i_pred_pc[PC_LSB+IDX_W-1:PC_LSB] ^ i_ghr;
  assign o_pred_idx = pred_idx;

`ifdef GSHARE_BYPASS_EN
  always_comb begin
    pred_cnt = pht[pred_idx];
    if (i_upd_valid && (i_upd_idx == pred_idx))
      pred_cnt = sat_update(pht[i_upd_idx], i_upd_taken);
  end
`else
  always_comb begin
    pred_cnt = pht[pred_idx];
  end
`endif

  // Gate with reset so a forwarded update cannot predict taken while held in reset.
  assign o_pred_taken = pred_cnt[1] & i_reset;

  assign mispredict   = i_upd_valid & (i_upd_taken != i_upd_pred_taken);
  assign o_ghr_enable = i_upd_valid;
  assign o_ghr_bit    = i_upd_taken;
  assign o_mispredict = mispredict;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= CNT_INIT;
    end else if (i_upd_valid) begin
      pht[i_upd_idx] <= sat_update(pht[i_upd_idx], i_upd_taken);
    end
  end

  // Performance counters wrap freely.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (i_upd_valid) br_count      <= br_count + PERF_W'(1);
      if (mispredict)  mispred_count <= mispred_count + PERF_W'(1);
    end
  end

  assign o_br_count      = br_count;
  assign o_mispred_count = mispred_count;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with an in-order expected-value scoreboard.
module tb_gshare_pht;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pred_pc;
  logic [9:0]  i_ghr;
  logic        o_pred_taken;
  logic [9:0]  o_pred_idx;
  logic        i_upd_valid;
  logic [9:0]  i_upd_idx;
  logic        i_upd_taken;
  logic        i_upd_pred_taken;
  logic        o_ghr_enable;
  logic        o_ghr_bit;
  logic        o_mispredict;
  logic [31:0] o_br_count;
  logic [31:0] o_mispred_count;

  gshare_pht dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_pred_pc        (i_pred_pc),
    .i_ghr            (i_ghr),
    .o_pred_taken     (o_pred_taken),
    .o_pred_idx       (o_pred_idx),
    .i_upd_valid      (i_upd_valid),
    .i_upd_idx        (i_upd_idx),
    .i_upd_taken      (i_upd_taken),
    .i_upd_pred_taken (i_upd_pred_taken),
    .o_ghr_enable     (o_ghr_enable),
    .o_ghr_bit        (o_ghr_bit),
    .o_mispredict     (o_mispredict),
    .o_br_count       (o_br_count),
    .o_mispred_count  (o_mispred_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] br_m = 0;
  logic [31:0] mp_m = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic predict(input string tag, input logic [31:0] pc, input logic [9:0] ghr,
                         input logic exp_taken);
    i_pred_pc = pc;
    i_ghr     = ghr;
    #1;
    expect_val(tag, 32'(exp_taken));
    check(32'(o_pred_taken));
  endtask

  task automatic check_counts(input string tag);
    expect_val({tag, "_br"}, br_m);
    check(o_br_count);
    expect_val({tag, "_mp"}, mp_m);
    check(o_mispred_count);
  endtask

  // Drive one resolved branch for a full cycle, checking the combinational side outputs.
  task automatic upd(input logic [9:0] idx, input logic t, input logic pt);
    i_upd_valid      = 1'b1;
    i_upd_idx        = idx;
    i_upd_taken      = t;
    i_upd_pred_taken = pt;
    #1;
    expect_val("ghr_en", 32'd1);
    check(32'(o_ghr_enable));
    expect_val("ghr_bit", 32'(t));
    check(32'(o_ghr_bit));
    expect_val("mispred", 32'(t != pt));
    check(32'(o_mispredict));
    @(posedge i_clk);
    #1;
    i_upd_valid = 1'b0;
    br_m = br_m + 32'd1;
    if (t != pt) mp_m = mp_m + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset          = 1'b0;
    i_pred_pc        = 32'h40;
    i_ghr            = 10'h0;
    i_upd_valid      = 1'b0;
    i_upd_idx        = 10'h0;
    i_upd_taken      = 1'b0;
    i_upd_pred_taken = 1'b0;

    // Reset state and release
    #2;
    expect_val("rst_pred_in_reset", 32'd0);
    check(32'(o_pred_taken));
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    expect_val("rst_idx", 32'h010);
    check(32'(o_pred_idx));
    expect_val("rst_pred", 32'd0);
    check(32'(o_pred_taken));
    check_counts("rst");
    @(posedge i_clk);
    #1;

    // Index hash
    i_pred_pc = 32'h0000_0FFC;
    i_ghr     = 10'h3FF;
    #1;
    expect_val("idx_allones", 32'h000);
    check(32'(o_pred_idx));
    i_pred_pc = 32'h8;
    i_ghr     = 10'h001;
    #1;
    expect_val("idx_xor", 32'h003);
    check(32'(o_pred_idx));
    i_pred_pc = 32'hFFFF_F014;
    i_ghr     = 10'h2A0;
    #1;
    expect_val("idx_highpc", 32'h005 ^ 32'h2A0);
    check(32'(o_pred_idx));

    // Idle resolve port: no GHR shift, no mispredict even when outcome differs
    i_upd_taken      = 1'b1;
    i_upd_pred_taken = 1'b0;
    #1;
    expect_val("idle_ghr_en", 32'd0);
    check(32'(o_ghr_enable));
    expect_val("idle_mispred", 32'd0);
    check(32'(o_mispredict));

    // Saturation on idx 5
    upd(10'd5, 1'b1, 1'b0);
    predict("sat_t1", 32'h14, 10'h0, 1'b1);
    upd(10'd5, 1'b1, 1'b1);
    upd(10'd5, 1'b1, 1'b1);
    predict("sat_t3", 32'h14, 10'h0, 1'b1);
    upd(10'd5, 1'b1, 1'b1);
    upd(10'd5, 1'b0, 1'b1);
    predict("sat_st_to_wt", 32'h14, 10'h0, 1'b1);
    upd(10'd5, 1'b0, 1'b1);
    predict("sat_wnt", 32'h14, 10'h0, 1'b0);
    upd(10'd5, 1'b0, 1'b0);
    upd(10'd5, 1'b0, 1'b0);
    upd(10'd5, 1'b1, 1'b0);
    predict("sat_snt_hold", 32'h14, 10'h0, 1'b0);
    upd(10'd5, 1'b1, 1'b0);
    predict("sat_back_wt", 32'h14, 10'h0, 1'b1);
    predict("sat_neighbor", 32'h18, 10'h0, 1'b0);
    check_counts("sat");

    // Read during write on idx 7 (starts WNT)
    i_pred_pc        = 32'h1C;
    i_ghr            = 10'h0;
    i_upd_valid      = 1'b1;
    i_upd_idx        = 10'd7;
    i_upd_taken      = 1'b1;
    i_upd_pred_taken = 1'b0;
    #1;
`ifdef GSHARE_BYPASS_EN
    expect_val("rdw_same_cycle", 32'd1);
`else
    expect_val("rdw_same_cycle", 32'd0);
`endif
    check(32'(o_pred_taken));
    @(posedge i_clk);
    #1;
    i_upd_valid = 1'b0;
    br_m = br_m + 32'd1;
    mp_m = mp_m + 32'd1;
    predict("rdw_next_cycle", 32'h1C, 10'h0, 1'b1);

    // Perf counters and GHR outputs
    upd(10'd100, 1'b1, 1'b1);
    upd(10'd100, 1'b0, 1'b1);
    upd(10'd100, 1'b1, 1'b0);
    upd(10'd100, 1'b0, 1'b0);
    check_counts("perf");

    // Reset mid-run with idx 5 trained to ST
    upd(10'd5, 1'b1, 1'b1);
    upd(10'd5, 1'b1, 1'b1);
    predict("pre_rst_st", 32'h14, 10'h0, 1'b1);
    #2;
    i_reset = 1'b0;
    br_m    = 0;
    mp_m    = 0;
    #1;
    expect_val("midrst_pred", 32'd0);
    check(32'(o_pred_taken));
    check_counts("midrst");
    i_upd_valid      = 1'b1;
    i_upd_idx        = 10'd5;
    i_upd_taken      = 1'b1;
    i_upd_pred_taken = 1'b0;
    i_ghr            = 10'h001;
    #1;
    expect_val("midrst_idx", 32'h004);
    check(32'(o_pred_idx));
    expect_val("midrst_ghr_en", 32'd1);
    check(32'(o_ghr_enable));
    expect_val("midrst_mispred", 32'd1);
    check(32'(o_mispredict));
    i_ghr = 10'h0;
    #1;
    expect_val("midrst_fwd_pred", 32'd0);
    check(32'(o_pred_taken));
    @(posedge i_clk);
    #1;
    check_counts("midrst_held");
    i_upd_valid = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    predict("post_rst_pred", 32'h14, 10'h0, 1'b0);
    upd(10'd5, 1'b1, 1'b0);
    check_counts("post_rst");
    predict("post_rst_wt", 32'h14, 10'h0, 1'b1);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
